// File: rtl/esfa_pkg.sv
// Definitions shared between the input streamer and the ESFA design:
// default symbol width, default verdict timeout, and the streamer state encoding.
package esfa_pkg;

  localparam int ESFA_SYM_W   = 8;
  localparam int ESFA_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FIN    = 2'd3
  } esfa_state_e;

  function automatic logic state_is_busy(esfa_state_e s);
    return (s == ST_STREAM) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/esfa_sym_buffer.sv
// Symbol store for one input string: DEPTH x SYM_W register array with a single
// write port and a registered read port that holds its value when not enabled.
module esfa_sym_buffer #(
  parameter  int SYM_W = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_idx,
  output logic [SYM_W-1:0] rd_data
);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] rd_data_d;
  logic [SYM_W-1:0] rd_data_q;

  // Contents are deliberately not reset; the streamer's count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/esfa_input_streamer.sv
// Loads a symbol string, streams it to the ESFA automaton over a valid/ready
// handshake, then waits (with a watchdog) for the accept/reject verdict.
module esfa_input_streamer
  import esfa_pkg::*;
#(
  parameter  int SYM_W   = ESFA_SYM_W,
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = ESFA_TIMEOUT,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1,
  localparam int WW      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             clear,
  output logic [CW-1:0]    count,
  output logic             full,
  input  logic             start,
  output logic             busy,
  output logic [SYM_W-1:0] sym_data,
  output logic             sym_valid,
  output logic             sym_last,
  input  logic             sym_ready,
  input  logic             res_valid,
  input  logic             res_accept,
  output logic             done,
  output logic             accepted,
  output logic             timed_out
);

  esfa_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          sym_valid_q, sym_valid_d;
  logic          sym_last_q, sym_last_d;
  logic          done_q, done_d;
  logic          accepted_q, accepted_d;
  logic          timed_out_q, timed_out_d;

  logic          buf_wr_en;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_idx;
  logic          full_w;

  assign full_w = (count_q == CW'(DEPTH));

  esfa_sym_buffer #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr_en),
    .wr_idx  (count_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (buf_rd_en),
    .rd_idx  (buf_rd_idx),
    .rd_data (sym_data)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    done_d      = 1'b0;
    accepted_d  = accepted_q;
    timed_out_d = timed_out_q;
    buf_wr_en   = 1'b0;
    buf_rd_en   = 1'b0;
    buf_rd_idx  = idx_q;

    case (state_q)
      ST_IDLE: begin
        // start takes priority so the string cannot change under a new run
        if (start) begin
          if (count_q != '0) begin
            state_d     = ST_STREAM;
            idx_d       = '0;
            buf_rd_en   = 1'b1;
            buf_rd_idx  = '0;
            sym_valid_d = 1'b1;
            sym_last_d  = (count_q == CW'(1));
          end else begin
            state_d     = ST_FIN;
            done_d      = 1'b1;
            accepted_d  = 1'b0;
            timed_out_d = 1'b0;
          end
        end else if (clear) begin
          count_d = '0;
        end else if (wr_en && !full_w) begin
          buf_wr_en = 1'b1;
          count_d   = count_q + CW'(1);
        end
      end

      ST_STREAM: begin
        if (sym_ready) begin
          if (sym_last_q) begin
            state_d     = ST_WAIT;
            sym_valid_d = 1'b0;
            sym_last_d  = 1'b0;
            wdog_d      = '0;
          end else begin
            idx_d      = idx_q + AW'(1);
            buf_rd_en  = 1'b1;
            buf_rd_idx = idx_q + AW'(1);
            // next index is the last one when idx+1 == count-1
            sym_last_d = (({1'b0, idx_q} + CW'(2)) == count_q);
          end
        end
      end

      ST_WAIT: begin
        if (res_valid) begin
          state_d     = ST_FIN;
          done_d      = 1'b1;
          accepted_d  = res_accept;
          timed_out_d = 1'b0;
        end else if (wdog_q == WW'(TIMEOUT)) begin
          state_d     = ST_FIN;
          done_d      = 1'b1;
          accepted_d  = 1'b0;
          timed_out_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      wdog_q      <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      done_q      <= 1'b0;
      accepted_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      done_q      <= done_d;
      accepted_q  <= accepted_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign count     = count_q;
  assign full      = full_w;
  assign busy      = state_is_busy(state_q);
  assign sym_valid = sym_valid_q;
  assign sym_last  = sym_last_q;
  assign done      = done_q;
  assign accepted  = accepted_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_esfa_input_streamer.sv
// Bench for esfa_input_streamer: scenario tasks plus a scoreboard of expected
// symbols that is consumed on every accepted handshake.
module tb_esfa_input_streamer;

  localparam int SW = 8;
  localparam int DP = 16;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [SW-1:0] wr_data;
  logic          clear;
  logic [4:0]    count;
  logic          full;
  logic          start;
  logic          busy;
  logic [SW-1:0] sym_data;
  logic          sym_valid;
  logic          sym_last;
  logic          sym_ready;
  logic          res_valid;
  logic          res_accept;
  logic          done;
  logic          accepted;
  logic          timed_out;

  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;

  esfa_input_streamer #(
    .SYM_W   (SW),
    .DEPTH   (DP),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clear      (clear),
    .count      (count),
    .full       (full),
    .start      (start),
    .busy       (busy),
    .sym_data   (sym_data),
    .sym_valid  (sym_valid),
    .sym_last   (sym_last),
    .sym_ready  (sym_ready),
    .res_valid  (res_valid),
    .res_accept (res_accept),
    .done       (done),
    .accepted   (accepted),
    .timed_out  (timed_out)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake that will complete on the next rising edge
  always @(negedge clk) begin
    if (!rst && sym_valid && sym_ready) begin
      exp_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got symbol %h last=%b, none expected", sym_data, sym_last);
      end else begin
        e = exp_q.pop_front();
        if (sym_data !== e.data || sym_last !== e.last) begin
          n_fail++;
          $display("FAIL sb_symbol: got %h last=%b, expected %h last=%b",
                   sym_data, sym_last, e.data, e.last);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [SW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (count !== 5'd0 || full !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: count=%0d full=%b busy=%b, expected 0 0 0", count, full, busy);
    end
    n_tests++;
    if (sym_valid !== 1'b0 || sym_last !== 1'b0 || sym_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_sym: valid=%b last=%b data=%h, expected 0 0 00", sym_valid, sym_last, sym_data);
    end
    n_tests++;
    if (done !== 1'b0 || accepted !== 1'b0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result: done=%b acc=%b to=%b, expected 0 0 0", done, accepted, timed_out);
    end
    rst = 1'b0;
    tick();
    res_valid  = 1'b1;
    res_accept = 1'b1;
    tick();
    res_valid  = 1'b0;
    n_tests++;
    if (done !== 1'b0 || accepted !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_res_ignored: done=%b acc=%b busy=%b, expected 0 0 0", done, accepted, busy);
    end
  endtask

  task automatic test_basic();
    logic [SW-1:0] exp_d [3] = '{8'h61, 8'h62, 8'h63};
    do_clear();
    for (int i = 0; i < 3; i++) load(exp_d[i]);
    n_tests++;
    if (count !== 5'd3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 3", count);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back('{data: exp_d[i], last: (i == 2)});
    sym_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (sym_valid !== 1'b1 || sym_data !== exp_d[i] || sym_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                 i, sym_valid, sym_data, sym_last, exp_d[i], (i == 2));
      end
      tick();
    end
    n_tests++;
    if (sym_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wait: valid=%b busy=%b, expected 0 1", sym_valid, busy);
    end
    tick();
    res_valid  = 1'b1;
    res_accept = 1'b1;
    tick();
    res_valid  = 1'b0;
    n_tests++;
    if (done !== 1'b1 || accepted !== 1'b1 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b acc=%b to=%b, expected 1 1 0", done, accepted, timed_out);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || accepted !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after: done=%b busy=%b acc=%b, expected 0 0 1", done, busy, accepted);
    end
  endtask

  task automatic test_empty();
    int n;
    do_clear();
    n_tests++;
    if (count !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_count: got %0d expected 0", count);
    end
    pulse_start();
    n = 1;
    while (!done && n < 2) begin
      tick();
      n++;
    end
    n_tests++;
    if (done !== 1'b1 || accepted !== 1'b0 || timed_out !== 1'b0 || sym_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: done=%b acc=%b to=%b valid=%b, expected 1 0 0 0",
               done, accepted, timed_out, sym_valid);
    end
    tick();
  endtask

  task automatic test_stall();
    logic          pat   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [SW-1:0] exp_d [5] = '{8'h61, 8'h62, 8'h62, 8'h62, 8'h63};
    do_clear();
    load(8'h61);
    load(8'h62);
    load(8'h63);
    for (int i = 0; i < 3; i++) exp_q.push_back('{data: 8'h61 + SW'(i), last: (i == 2)});
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      sym_ready = pat[i];
      n_tests++;
      if (sym_valid !== 1'b1 || sym_data !== exp_d[i]) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: valid=%b data=%h, expected 1 %h", i, sym_valid, sym_data, exp_d[i]);
      end
      tick();
    end
    n_tests++;
    if (sym_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_end: valid=%b pending=%0d, expected 0 0", sym_valid, exp_q.size());
    end
    res_valid  = 1'b1;
    res_accept = 1'b0;
    tick();
    res_valid  = 1'b0;
    n_tests++;
    if (done !== 1'b1 || accepted !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: done=%b acc=%b, expected 1 0", done, accepted);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    do_clear();
    load(8'h5A);
    exp_q.push_back('{data: 8'h5A, last: 1'b1});
    sym_ready = 1'b1;
    pulse_start();
    tick();
    n = 0;
    while (!done && n < TO + 10) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != TO + 1 || timed_out !== 1'b1 || accepted !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: cycles=%0d to=%b acc=%b, expected %0d 1 0", n, timed_out, accepted, TO + 1);
    end
    tick();
    // replay the retained string; verdict lands on the final watchdog cycle
    exp_q.push_back('{data: 8'h5A, last: 1'b1});
    pulse_start();
    tick();
    repeat (TO) tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_edge_early: done=%b busy=%b, expected 0 1", done, busy);
    end
    res_valid  = 1'b1;
    res_accept = 1'b1;
    tick();
    res_valid  = 1'b0;
    n_tests++;
    if (done !== 1'b1 || accepted !== 1'b1 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_tie: done=%b acc=%b to=%b, expected 1 1 0", done, accepted, timed_out);
    end
    tick();
  endtask

  task automatic test_full();
    int n;
    do_clear();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back('{data: 8'h10 + SW'(i), last: (i == 15)});
      load(8'h10 + SW'(i));
    end
    n_tests++;
    if (count !== 5'd16 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_count: count=%0d full=%b, expected 16 1", count, full);
    end
    sym_ready = 1'b1;
    pulse_start();
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    n = 0;
    while (sym_valid && n < 40) begin
      n++;
      tick();
      clear = 1'b0;
      wr_en = 1'b0;
    end
    n_tests++;
    if (n != 16 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL full_stream: symbols=%0d count=%0d, expected 16 16", n, count);
    end
    res_valid  = 1'b1;
    res_accept = 1'b1;
    tick();
    res_valid  = 1'b0;
    tick();
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    tick();
    clear   = 1'b0;
    wr_en   = 1'b0;
    n_tests++;
    if (count !== 5'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_wins: count=%0d full=%b, expected 0 0", count, full);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    for (int i = 0; i < 5; i++) load(8'h31 + SW'(i));
    exp_q.push_back('{data: 8'h31, last: 1'b0});
    exp_q.push_back('{data: 8'h32, last: 1'b0});
    sym_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    dc  = done_cnt;
    rst = 1'b1;
    #1;
    n_tests++;
    if (sym_valid !== 1'b0 || count !== 5'd0 || busy !== 1'b0 || sym_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset: valid=%b count=%0d busy=%b data=%h, expected 0 0 0 00",
               sym_valid, count, busy, sym_data);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (done_cnt != dc || accepted !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_after: done_pulses=%0d acc=%b pending=%0d, expected 0 0 0",
               done_cnt - dc, accepted, exp_q.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    clear      = 1'b0;
    start      = 1'b0;
    sym_ready  = 1'b0;
    res_valid  = 1'b0;
    res_accept = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_timeout();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/esfa_input_streamer.md
ESFA_INPUT_STREAMER -- requirements
Module: esfa_input_streamer

Interface
REQ-001 Parameter SYM_W, default 8, symbol width in bits.
REQ-002 Parameter DEPTH, default 16, symbol buffer entries (power of two).
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for a verdict.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wr_en  in  1  load one symbol into the buffer.
REQ-007 wr_data  in  SYM_W  symbol to load.
REQ-008 clear  in  1  empty the buffer (count to 0).
REQ-009 count  out  log2(DEPTH)+1  symbols loaded.
REQ-010 full  out  1  count == DEPTH.
REQ-011 start  in  1  pulse: begin streaming the buffer to the automaton.
REQ-012 busy  out  1  high in STREAM or WAIT.
REQ-013 sym_data  out  SYM_W  symbol presented to the ESFA design.
REQ-014 sym_valid  out  1  sym_data valid.
REQ-015 sym_last  out  1  current symbol is the final one of the string.
REQ-016 sym_ready  in  1  ESFA design accepts the symbol.
REQ-017 res_valid  in  1  ESFA verdict strobe.
REQ-018 res_accept  in  1  ESFA verdict: 1 = string accepted.
REQ-019 done  out  1  one-cycle pulse when a run finishes.
REQ-020 accepted  out  1  registered verdict of last run.
REQ-021 timed_out  out  1  registered: last run ended by watchdog.

Function
REQ-022 FSM states IDLE, STREAM, WAIT, FIN; FIN lasts exactly one cycle, then IDLE.
REQ-023 IDLE: wr_en with !full writes wr_data at index count, count+1; wr_en when full ignored; clear sets count 0; clear and wr_en same cycle -> clear wins.
REQ-024 wr_en, clear ignored outside IDLE.
REQ-025 IDLE + start + count>0 -> STREAM, read index 0; start + count==0 -> FIN with accepted=0, timed_out=0, no symbol sent.
REQ-026 start outside IDLE ignored.
REQ-027 STREAM: sym_valid=1, sym_data=buffer[idx], sym_last = (idx == count-1); all registered outputs, no combinational path from sym_ready.
REQ-028 sym_data/sym_last held stable while sym_valid && !sym_ready.
REQ-029 sym_valid && sym_ready advances idx; on last symbol -> WAIT, sym_valid 0 next cycle; one symbol per cycle at full throughput.
REQ-030 WAIT: watchdog counter cleared on entry, increments each cycle; res_valid -> FIN, accepted=res_accept, timed_out=0.
REQ-031 WAIT: counter reaching TIMEOUT without res_valid -> FIN, accepted=0, timed_out=1; res_valid on same cycle wins.
REQ-032 res_valid outside WAIT ignored.
REQ-033 FIN: done=1; buffer and count retained so the same string may be replayed by another start.
REQ-034 accepted/timed_out hold until next FIN.

Reset
REQ-035 rst asserted at any time forces IDLE immediately; count, idx, watchdog=0; sym_valid, sym_last, done, accepted, timed_out, busy=0; sym_data=0.
REQ-036 Buffer contents not reset; unreadable because count=0.
REQ-037 Reset during STREAM drops sym_valid asynchronously; no partial run reported.

Structure
REQ-038 Shared package esfa_pkg holds SYM_W default, state encoding constants, and TIMEOUT default, shared with ESFADesign.
REQ-039 One sub-module esfa_sym_buffer: DEPTH x SYM_W register array, write port, registered read by index.
REQ-040 FSM, index, watchdog and handshake registers live in esfa_input_streamer.

Verification
REQ-041 Load 0x61,0x62,0x63, start, sym_ready=1 -> symbols on 3 consecutive cycles, sym_last with 0x63 only; res_valid+res_accept=1 two cycles later -> done pulse, accepted=1.
REQ-042 Same load, sym_ready toggled 1,0,0,1,1 -> each symbol held while stalled, none skipped or duplicated, order 0x61,0x62,0x63.
REQ-043 Start with count=0 -> done within 2 cycles, accepted=0, sym_valid never high.
REQ-044 Stream 1 symbol, no res_valid -> done exactly TIMEOUT+1 cycles after WAIT entry, timed_out=1, accepted=0.
REQ-045 Write 17 symbols with DEPTH=16 -> count=16, full=1, 17th dropped; streaming emits 16 symbols.
REQ-046 Assert rst mid-STREAM after 2 of 5 symbols -> sym_valid 0 same cycle, count=0, busy=0, no done pulse.
